// File: rtl/dpram_sync.sv
// Single-clock true dual-port RAM with byte-masked writes, registered reads and a post-reset clear engine.
// Optional per-lane even parity with error flags and injection hooks when DPRAM_PARITY_EN is defined.
module dpram_sync #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 11,
    parameter int BYTE_W     = 8,
    parameter int RD_MODE    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       init_done,
    input  logic                       a_en,
    input  logic [DATA_W/BYTE_W-1:0]   a_we,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_din,
    output logic [DATA_W-1:0]          a_dout,
    output logic                       a_valid,
    input  logic                       b_en,
    input  logic [DATA_W/BYTE_W-1:0]   b_we,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_din,
    output logic [DATA_W-1:0]          b_dout,
    output logic                       b_valid,
`ifdef DPRAM_PARITY_EN
    input  logic                       a_perr_inj,
    input  logic                       b_perr_inj,
    output logic                       a_perr,
    output logic                       b_perr,
`endif
    output logic                       collision
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_we;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic              collision_q, collision_d;

    logic              a_act, b_act;
    logic [NB-1:0]     a_wr, b_wr;
    logic [DATA_W-1:0] a_old, b_old, a_rdata, b_rdata;

    function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     wr);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int i = 0; i < NB; i++) begin
            if (wr[i]) m[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
        end
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            S_RESET: begin
                clr_cnt_d = '0;
                state_d   = (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
            end
            S_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = S_READY;
            end
            S_READY: ;
            default: state_d = S_RESET;
        endcase
        init_done_d = (state_d == S_READY) || (INIT_CLEAR == 0);
    end

    always_comb begin
        a_act = init_done_q & a_en;
        b_act = init_done_q & b_en;
        a_wr  = a_we & {NB{a_act}};
        b_wr  = b_we & {NB{b_act}};
        a_old = mem[a_addr];
        b_old = mem[b_addr];
        // Each port only folds in its own write lanes; the other port always sees the old word.
        a_rdata = (RD_MODE != 0) ? merge_word(a_old, a_din, a_wr) : a_old;
        b_rdata = (RD_MODE != 0) ? merge_word(b_old, b_din, b_wr) : b_old;
        a_dout_d    = a_act ? a_rdata : a_dout_q;
        b_dout_d    = b_act ? b_rdata : b_dout_q;
        a_valid_d   = a_act;
        b_valid_d   = b_act;
        collision_d = a_act & b_act & (a_addr == b_addr) & ((|a_wr) | (|b_wr));
    end

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] a_wpar, b_wpar, a_rpar, b_rpar;
    logic          a_perr_q, a_perr_d, b_perr_q, b_perr_d;

    function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[i*BYTE_W +: BYTE_W];
        return p;
    endfunction

    always_comb begin
        a_wpar    = lane_par(a_din);
        b_wpar    = lane_par(b_din);
        a_wpar[0] = a_wpar[0] ^ a_perr_inj;
        b_wpar[0] = b_wpar[0] ^ b_perr_inj;
        a_rpar = (RD_MODE != 0) ? ((par_mem[a_addr] & ~a_wr) | (a_wpar & a_wr)) : par_mem[a_addr];
        b_rpar = (RD_MODE != 0) ? ((par_mem[b_addr] & ~b_wr) | (b_wpar & b_wr)) : par_mem[b_addr];
        a_perr_d = a_act & (|(lane_par(a_rdata) ^ a_rpar));
        b_perr_d = b_act & (|(lane_par(b_rdata) ^ b_rpar));
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr[i]) par_mem[b_addr][i] <= b_wpar[i];
                if (a_wr[i]) par_mem[a_addr][i] <= a_wpar[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_perr_q <= 1'b0;
            b_perr_q <= 1'b0;
        end else begin
            a_perr_q <= a_perr_d;
            b_perr_q <= b_perr_d;
        end
    end

    assign a_perr = a_perr_q;
    assign b_perr = b_perr_q;
`endif

    // Port A's lane write is issued after port B's so A wins overlapping lanes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr[i]) mem[b_addr][i*BYTE_W +: BYTE_W] <= b_din[i*BYTE_W +: BYTE_W];
                if (a_wr[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            clr_cnt_q   <= '0;
            init_done_q <= (INIT_CLEAR == 0);
            a_dout_q    <= '0;
            b_dout_q    <= '0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            collision_q <= collision_d;
        end
    end

    assign init_done = init_done_q;
    assign a_dout    = a_dout_q;
    assign b_dout    = b_dout_q;
    assign a_valid   = a_valid_q;
    assign b_valid   = b_valid_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dpram_sync.sv
// Directed table-driven bench for dpram_sync: a read-first instance with clear engine
// and a small write-first instance without clear.
module tb_dpram_sync;

    logic clk;
    logic rst_n;

    logic        a_en, b_en, a_valid, b_valid, collision, init_done;
    logic [3:0]  a_we, b_we;
    logic [10:0] a_addr, b_addr;
    logic [31:0] a_din, b_din, a_dout, b_dout;

    logic        w_a_en, w_b_en, w_a_valid, w_b_valid, w_collision, w_init_done;
    logic [3:0]  w_a_we, w_b_we;
    logic [3:0]  w_a_addr, w_b_addr;
    logic [31:0] w_a_din, w_b_din, w_a_dout, w_b_dout;

`ifdef DPRAM_PARITY_EN
    logic a_perr_inj, b_perr_inj, a_perr, b_perr;
    logic w_a_perr_inj, w_b_perr_inj, w_a_perr, w_b_perr;
`endif

    dpram_sync #(.DATA_W(32), .ADDR_W(11), .BYTE_W(8), .RD_MODE(0), .INIT_CLEAR(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid),
`ifdef DPRAM_PARITY_EN
        .a_perr_inj(a_perr_inj), .b_perr_inj(b_perr_inj), .a_perr(a_perr), .b_perr(b_perr),
`endif
        .collision(collision)
    );

    dpram_sync #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_MODE(1), .INIT_CLEAR(0)) u_dut_wf (
        .clk(clk), .rst_n(rst_n), .init_done(w_init_done),
        .a_en(w_a_en), .a_we(w_a_we), .a_addr(w_a_addr), .a_din(w_a_din), .a_dout(w_a_dout), .a_valid(w_a_valid),
        .b_en(w_b_en), .b_we(w_b_we), .b_addr(w_b_addr), .b_din(w_b_din), .b_dout(w_b_dout), .b_valid(w_b_valid),
`ifdef DPRAM_PARITY_EN
        .a_perr_inj(w_a_perr_inj), .b_perr_inj(w_b_perr_inj), .a_perr(w_a_perr), .b_perr(w_b_perr),
`endif
        .collision(w_collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        a_en;
        logic [3:0]  a_we;
        logic [10:0] a_addr;
        logic [31:0] a_din;
        logic        b_en;
        logic [3:0]  b_we;
        logic [10:0] b_addr;
        logic [31:0] b_din;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_coll;
    } vec_t;

    vec_t vecs  [17];
    vec_t wvecs [5];
    int   total = 0;
    int   bad   = 0;
    int   n_edges;

    function automatic vec_t mk(input logic ae, input logic [3:0] awe, input logic [10:0] aa, input logic [31:0] ad,
                                input logic be, input logic [3:0] bwe, input logic [10:0] ba, input logic [31:0] bd,
                                input logic [31:0] ea, input logic [31:0] eb, input logic ec);
        vec_t v;
        v.a_en = ae; v.a_we = awe; v.a_addr = aa; v.a_din = ad;
        v.b_en = be; v.b_we = bwe; v.b_addr = ba; v.b_din = bd;
        v.exp_a = ea; v.exp_b = eb; v.exp_coll = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        a_en = 0; a_we = 0; a_addr = 0; a_din = 0;
        b_en = 0; b_we = 0; b_addr = 0; b_din = 0;
        w_a_en = 0; w_a_we = 0; w_a_addr = 0; w_a_din = 0;
        w_b_en = 0; w_b_we = 0; w_b_addr = 0; w_b_din = 0;
`ifdef DPRAM_PARITY_EN
        a_perr_inj = 0; b_perr_inj = 0; w_a_perr_inj = 0; w_b_perr_inj = 0;
`endif
    endtask

    // Called at a negedge: drive, take one rising edge, sample at the next negedge.
    task automatic run_vec(input vec_t v, input string tag, input bit wf);
        logic [31:0] ad, bd;
        logic        av, bv, co;
        if (!wf) begin
            a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_din = v.a_din;
            b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_din = v.b_din;
        end else begin
            w_a_en = v.a_en; w_a_we = v.a_we; w_a_addr = v.a_addr[3:0]; w_a_din = v.a_din;
            w_b_en = v.b_en; w_b_we = v.b_we; w_b_addr = v.b_addr[3:0]; w_b_din = v.b_din;
        end
        @(posedge clk);
        @(negedge clk);
        ad = wf ? w_a_dout  : a_dout;
        bd = wf ? w_b_dout  : b_dout;
        av = wf ? w_a_valid : a_valid;
        bv = wf ? w_b_valid : b_valid;
        co = wf ? w_collision : collision;
        $display("%s a_dout=%h a_valid=%b b_dout=%h b_valid=%b collision=%b", tag, ad, av, bd, bv, co);
        chk({tag, " a_valid"},   {31'b0, av}, {31'b0, v.a_en});
        chk({tag, " b_valid"},   {31'b0, bv}, {31'b0, v.b_en});
        chk({tag, " a_dout"},    ad, v.exp_a);
        chk({tag, " b_dout"},    bd, v.exp_b);
        chk({tag, " collision"}, {31'b0, co}, {31'b0, v.exp_coll});
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (n < 5000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                chk("pre-init a_valid", {31'b0, a_valid}, 32'd0);
                chk("pre-init a_dout",  a_dout, 32'd0);
                a_en = 0;
            end
            if (init_done) break;
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 4'h0, 11'h005, 32'h0,        0, 4'h0, 11'h000, 32'h0,        32'h0,        32'h0,        0);
        vecs[1]  = mk(1, 4'hF, 11'h010, 32'hDEADBEEF, 0, 4'h0, 11'h000, 32'h0,        32'h0,        32'h0,        0);
        vecs[2]  = mk(0, 4'h0, 11'h000, 32'h0,        1, 4'h0, 11'h010, 32'h0,        32'h0,        32'hDEADBEEF, 0);
        vecs[3]  = mk(1, 4'hF, 11'h020, 32'h11223344, 0, 4'h0, 11'h000, 32'h0,        32'h0,        32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 4'h5, 11'h020, 32'hAABBCCDD, 0, 4'h0, 11'h000, 32'h0,        32'h11223344, 32'hDEADBEEF, 0);
        vecs[5]  = mk(1, 4'h0, 11'h020, 32'h0,        0, 4'h0, 11'h000, 32'h0,        32'h11BB33DD, 32'hDEADBEEF, 0);
        vecs[6]  = mk(1, 4'hF, 11'h030, 32'h1,        0, 4'h0, 11'h000, 32'h0,        32'h0,        32'hDEADBEEF, 0);
        vecs[7]  = mk(1, 4'hF, 11'h030, 32'h2,        0, 4'h0, 11'h000, 32'h0,        32'h1,        32'hDEADBEEF, 0);
        vecs[8]  = mk(1, 4'hF, 11'h040, 32'h5,        1, 4'hF, 11'h040, 32'h9,        32'h0,        32'h0,        1);
        vecs[9]  = mk(1, 4'h0, 11'h040, 32'h0,        1, 4'h0, 11'h030, 32'h0,        32'h5,        32'h2,        0);
        vecs[10] = mk(1, 4'hF, 11'h040, 32'h7,        1, 4'h0, 11'h040, 32'h0,        32'h5,        32'h5,        1);
        vecs[11] = mk(1, 4'h0, 11'h040, 32'h0,        1, 4'h0, 11'h040, 32'h0,        32'h7,        32'h7,        0);
        vecs[12] = mk(1, 4'h0, 11'h010, 32'h0,        1, 4'h3, 11'h010, 32'h00001234, 32'hDEADBEEF, 32'hDEADBEEF, 1);
        vecs[13] = mk(1, 4'h0, 11'h010, 32'h0,        1, 4'h0, 11'h010, 32'h0,        32'hDEAD1234, 32'hDEAD1234, 0);
        vecs[14] = mk(1, 4'hC, 11'h050, 32'hAAAA0000, 1, 4'h6, 11'h050, 32'h00BBBB00, 32'h0,        32'h0,        1);
        vecs[15] = mk(1, 4'h0, 11'h050, 32'h0,        1, 4'h0, 11'h050, 32'h0,        32'hAAAABB00, 32'hAAAABB00, 0);
        vecs[16] = mk(0, 4'h0, 11'h000, 32'h0,        0, 4'h0, 11'h000, 32'h0,        32'hAAAABB00, 32'hAAAABB00, 0);

        wvecs[0] = mk(1, 4'hF, 11'h003, 32'h1,        0, 4'h0, 11'h000, 32'h0,        32'h1,        32'h0,        0);
        wvecs[1] = mk(1, 4'hF, 11'h003, 32'h2,        0, 4'h0, 11'h000, 32'h0,        32'h2,        32'h0,        0);
        wvecs[2] = mk(1, 4'h1, 11'h003, 32'h000000FF, 0, 4'h0, 11'h000, 32'h0,        32'hFF,       32'h0,        0);
        wvecs[3] = mk(1, 4'hF, 11'h003, 32'h100,      1, 4'h0, 11'h003, 32'h0,        32'h100,      32'hFF,       1);
        wvecs[4] = mk(0, 4'h0, 11'h000, 32'h0,        1, 4'h0, 11'h003, 32'h0,        32'h100,      32'h100,      0);

        set_idle();
        rst_n = 1'b0;
        #12;
        chk("reset a_dout",       a_dout, 32'd0);
        chk("reset b_dout",       b_dout, 32'd0);
        chk("reset a_valid",      {31'b0, a_valid}, 32'd0);
        chk("reset b_valid",      {31'b0, b_valid}, 32'd0);
        chk("reset collision",    {31'b0, collision}, 32'd0);
        chk("reset init_done",    {31'b0, init_done}, 32'd0);
        chk("reset wf init_done", {31'b0, w_init_done}, 32'd1);

        // Reset pulse in the middle of the clear: the clear must restart from address 0.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (101) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-clear init_done", {31'b0, init_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_en = 1; a_addr = 11'h005;
        wait_init(n_edges);
        $display("init after clear restart: edges=%0d", n_edges);
        chk("init edges after restart", n_edges, 32'd2049);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        for (int i = 0; i < 5; i++)  run_vec(wvecs[i], $sformatf("wvec%0d", i), 1'b1);
        set_idle();

`ifdef DPRAM_PARITY_EN
        a_en = 1; a_we = 4'hF; a_addr = 11'h060; a_din = 32'h12345678; a_perr_inj = 1;
        @(posedge clk); @(negedge clk);
        $display("perr write a_perr=%b a_valid=%b", a_perr, a_valid);
        chk("perr on inj write (old word)", {31'b0, a_perr}, 32'd0);
        a_we = 4'h0; a_din = 0; a_perr_inj = 0;
        @(posedge clk); @(negedge clk);
        $display("perr read a_perr=%b a_valid=%b a_dout=%h", a_perr, a_valid, a_dout);
        chk("perr readback a_valid", {31'b0, a_valid}, 32'd1);
        chk("perr readback a_perr",  {31'b0, a_perr}, 32'd1);
        chk("perr readback a_dout",  a_dout, 32'h12345678);
        a_addr = 11'h050;
        @(posedge clk); @(negedge clk);
        $display("perr clean read a_perr=%b", a_perr);
        chk("perr clean read", {31'b0, a_perr}, 32'd0);
        a_en = 0;
        @(posedge clk); @(negedge clk);
        chk("perr idle", {31'b0, a_perr}, 32'd0);
`endif

        // Asynchronous reset mid-operation: outputs drop without waiting for a clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("async rst a_dout",    a_dout, 32'd0);
        chk("async rst b_dout",    b_dout, 32'd0);
        chk("async rst init_done", {31'b0, init_done}, 32'd0);
        chk("async rst wf a_dout", w_a_dout, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n_edges);
        $display("init after op reset: edges=%0d", n_edges);
        chk("init edges after op reset", n_edges, 32'd2049);
        run_vec(mk(1, 4'h0, 11'h010, 32'h0, 1, 4'h0, 11'h050, 32'h0, 32'h0, 32'h0, 0), "cleared", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
